// File: rtl/seg7_scan_4.sv
// seg7_scan_4
// Multiplexed 4-digit 7-segment display driver. The four BCD digits take turns
// on one shared segment bus. Each digit slot lasts REFRESH_DIV clocks. The
// first GUARD clocks of every slot keep all anodes off, which suppresses
// ghosting. The digits and decimal points are captured once per frame, so a
// carry in the upstream counter during a scan cannot tear the displayed value.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   enable       1 = scan, 0 = freeze scan position and blank the display
//   s1000..s1    BCD digits for slots 3..0
//   blank_lz     1 = blank leading zeros in slots 3..1
//   dp_en        decimal-point enable, bit n belongs to slot n
//   an           anode enables, bit n selects slot n
//   seg          segments {g,f,e,d,c,b,a}
//   dp           decimal point
//   frame_start  one-cycle pulse after each snapshot load
module seg7_scan_4 #(
    parameter int REFRESH_DIV    = 50000,
    parameter int GUARD          = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [3:0] s1000,
    input  logic [3:0] s100,
    input  logic [3:0] s10,
    input  logic [3:0] s1,
    input  logic       blank_lz,
    input  logic [3:0] dp_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST_CNT  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_CNT = CW'(GUARD);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [3:0]    snap3, snap2, snap1, snap0;
    logic [3:0]    snap_dp;
    logic          first;

    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q;

    logic          slot_end;
    logic          load;
    logic          in_guard;
    logic          blanked;
    logic [3:0]    cur_digit;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;

    // Active-high segment pattern {g,f,e,d,c,b,a}; non-BCD codes show a dash.
    function automatic logic [6:0] decode_digit(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b1000000;
        endcase
    endfunction

    // Next-output and snapshot-load decisions, all from the state before the edge.
    // A slot is blanked only if it and every higher slot hold zero, so a
    // non-BCD code in a higher slot keeps the lower zeros visible.
    always_comb begin
        slot_end  = (cnt == LAST_CNT);
        load      = first || (slot_end && (idx == 2'd3));
        in_guard  = (cnt < GUARD_CNT);
        cur_digit = snap0;
        blanked   = 1'b0;
        case (idx)
            2'd0: begin
                cur_digit = snap0;
                blanked   = 1'b0;
            end
            2'd1: begin
                cur_digit = snap1;
                blanked   = blank_lz && (snap3 == 4'd0) && (snap2 == 4'd0) && (snap1 == 4'd0);
            end
            2'd2: begin
                cur_digit = snap2;
                blanked   = blank_lz && (snap3 == 4'd0) && (snap2 == 4'd0);
            end
            default: begin
                cur_digit = snap3;
                blanked   = blank_lz && (snap3 == 4'd0);
            end
        endcase

        an_next  = 4'b0000;
        seg_next = 7'b0000000;
        dp_next  = 1'b0;
        if (!in_guard) begin
            an_next  = 4'b0001 << idx;
            seg_next = blanked ? 7'b0000000 : decode_digit(cur_digit);
            dp_next  = snap_dp[idx];
        end
    end

    // Scan position, snapshot and registered outputs. While disabled the scan
    // position and snapshot hold and the outputs go dark.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            idx         <= 2'd0;
            snap3       <= 4'd0;
            snap2       <= 4'd0;
            snap1       <= 4'd0;
            snap0       <= 4'd0;
            snap_dp     <= 4'd0;
            first       <= 1'b1;
            an_q        <= 4'b0000;
            seg_q       <= 7'b0000000;
            dp_q        <= 1'b0;
            frame_start <= 1'b0;
        end else if (enable) begin
            an_q        <= an_next;
            seg_q       <= seg_next;
            dp_q        <= dp_next;
            frame_start <= load;
            if (slot_end) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (load) begin
                snap3   <= s1000;
                snap2   <= s100;
                snap1   <= s10;
                snap0   <= s1;
                snap_dp <= dp_en;
                first   <= 1'b0;
            end
        end else begin
            an_q        <= 4'b0000;
            seg_q       <= 7'b0000000;
            dp_q        <= 1'b0;
            frame_start <= 1'b0;
        end
    end

    // Polarity applies only at the pins.
    assign an  = (AN_ACTIVE_LOW  != 0) ? ~an_q  : an_q;
    assign seg = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign dp  = (SEG_ACTIVE_LOW != 0) ? ~dp_q  : dp_q;

endmodule
